// File: rtl/result_bram_drain_if.sv
// Row stream produced by result_bram_drain: valid/ready handshake with
// lane-packed data and an end-of-drain marker.
interface result_bram_drain_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 32
) ();

  logic                      m_valid;
  logic                      m_ready;
  logic [LANES*DATA_W-1:0]   m_data;
  logic                      m_last;

  // Drain side drives the row; consumer returns ready.
  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/result_bram_drain.sv
// Walks the result BRAM via port B and streams rows out with credit-based
// read issue. Optional running lane checksum under DRAIN_CHECKSUM_EN.
module result_bram_drain #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned LANES        = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [ADDR_W:0]                num_rows,
  output logic [ADDR_W-1:0]              bram_addr,
  output logic                           bram_en,
  input  logic [LANES-1:0][DATA_W-1:0]   bram_dout,
  result_bram_drain_if.master            stream,
  output logic                           busy,
  output logic                           done,
  output logic [31:0]                    checksum
);

  localparam int unsigned ROW_W  = LANES * DATA_W;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CRD_W  = CNT_W + 1;

  localparam logic [ADDR_W:0] ROWS_MAX = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state, state_n;
  logic [ADDR_W:0]         rows, rows_n;
  logic [ADDR_W:0]         issued, issued_n;
  logic [ADDR_W:0]         pushed, pushed_n;
  logic [ADDR_W:0]         rows_clamp;
  logic [CNT_W-1:0]        occ, occ_n;
  logic [CNT_W-1:0]        pend, pend_n;
  logic [PTR_W-1:0]        wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0]        rd_ptr, rd_ptr_n;
  logic [READ_LATENCY-1:0] rd_pipe;
  logic [ROW_W-1:0]        mem   [FIFO_DEPTH];
  logic [ROW_W-1:0]        mem_n [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   last_mem, last_mem_n;

  logic                    push;
  logic                    pop;
  logic                    en_n;
  logic [ADDR_W-1:0]       addr_n;
  logic                    valid_n;
  logic [ROW_W-1:0]        data_n;
  logic                    last_n;
  logic                    busy_n;
  logic                    done_n;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rows_clamp = (num_rows > ROWS_MAX) ? ROWS_MAX : num_rows;
  assign push       = rd_pipe[READ_LATENCY-1];
  assign pop        = stream.m_valid && stream.m_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state, FIFO bookkeeping and credit-gated read issue
  always_comb begin
    state_n    = state;
    rows_n     = rows;
    issued_n   = issued;
    pushed_n   = pushed;
    occ_n      = occ;
    pend_n     = pend;
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    mem_n      = mem;
    last_mem_n = last_mem;
    en_n       = 1'b0;
    addr_n     = bram_addr;
    valid_n    = 1'b0;
    data_n     = stream.m_data;
    last_n     = 1'b0;
    busy_n     = 1'b0;
    done_n     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          rows_n   = rows_clamp;
          issued_n = '0;
          pushed_n = '0;
          state_n  = (rows_clamp == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issued == rows) state_n = S_FLUSH;
      end
      S_FLUSH: begin
        if (pop && stream.m_last) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Returning read data lands in the FIFO tagged with its end-of-drain flag
    if (push) begin
      mem_n[wr_ptr]      = bram_dout;
      last_mem_n[wr_ptr] = (pushed == rows - (ADDR_W+1)'(1));
      wr_ptr_n           = ptr_inc(wr_ptr);
      pushed_n           = pushed + (ADDR_W+1)'(1);
    end
    if (pop) rd_ptr_n = ptr_inc(rd_ptr);

    occ_n  = occ + CNT_W'(push) - CNT_W'(pop);
    pend_n = pend + CNT_W'(bram_en) - CNT_W'(push);

    // Every slot is reserved at issue time, so the FIFO can never overflow
    if ((state_n == S_RUN) && (issued_n < rows_n) &&
        ((CRD_W'(occ_n) + CRD_W'(pend_n)) < CRD_W'(FIFO_DEPTH))) begin
      en_n     = 1'b1;
      addr_n   = issued_n[ADDR_W-1:0];
      issued_n = issued_n + (ADDR_W+1)'(1);
    end

    valid_n = (occ_n != '0);
    if (valid_n) begin
      data_n = mem_n[rd_ptr_n];
      last_n = last_mem_n[rd_ptr_n];
    end

    busy_n = (state_n == S_RUN) || (state_n == S_FLUSH);
    done_n = (state_n == S_DONE);
  end

  // Control, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rows           <= '0;
      issued         <= '0;
      pushed         <= '0;
      occ            <= '0;
      pend           <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rd_pipe        <= '0;
      last_mem       <= '0;
      bram_en        <= 1'b0;
      bram_addr      <= '0;
      stream.m_valid <= 1'b0;
      stream.m_data  <= '0;
      stream.m_last  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      rows           <= rows_n;
      issued         <= issued_n;
      pushed         <= pushed_n;
      occ            <= occ_n;
      pend           <= pend_n;
      wr_ptr         <= wr_ptr_n;
      rd_ptr         <= rd_ptr_n;
      rd_pipe        <= READ_LATENCY'({rd_pipe, bram_en});
      last_mem       <= last_mem_n;
      bram_en        <= en_n;
      bram_addr      <= addr_n;
      stream.m_valid <= valid_n;
      stream.m_data  <= data_n;
      stream.m_last  <= last_n;
      busy           <= busy_n;
      done           <= done_n;
    end
  end

  // Row storage needs no reset: occupancy gates every read of it
  always_ff @(posedge clk) begin
    mem <= mem_n;
  end

`ifdef DRAIN_CHECKSUM_EN
  logic [31:0] lane_sum;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      lane_sum = lane_sum + 32'(stream.m_data[DATA_W*i +: DATA_W]);
    end
  end

  // Accumulates transferred rows; cleared by an accepted start
  always_ff @(posedge clk) begin
    if (!rstn)                        checksum <= '0;
    else if ((state == S_IDLE) && start) checksum <= '0;
    else if (pop)                     checksum <= checksum + lane_sum;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_result_bram_drain.sv
// Directed bench for result_bram_drain with a two-cycle BRAM port B model.
module tb_result_bram_drain;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 4;

  logic                clk = 1'b0;
  logic                rstn;
  logic                start;
  logic [ADDR_W:0]     num_rows;
  logic [ADDR_W-1:0]   bram_addr;
  logic                bram_en;
  logic [3:0][31:0]    bram_dout;
  logic                busy;
  logic                done;
  logic [31:0]         checksum;

  result_bram_drain_if #(.LANES(4), .DATA_W(32)) stream_if ();

  result_bram_drain dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .num_rows  (num_rows),
    .bram_addr (bram_addr),
    .bram_en   (bram_en),
    .bram_dout (bram_dout),
    .stream    (stream_if.master),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  // BRAM port B: address registered, then output registered
  logic [3:0][31:0] bram_mem [1024];
  logic [3:0][31:0] bram_p1;
  always @(posedge clk) begin
    bram_p1   <= bram_mem[bram_addr];
    bram_dout <= bram_p1;
  end

  int compared = 0;
  int mismatched = 0;

  // Stream monitor sampled mid-cycle
  logic [127:0] rx_data [$];
  logic         rx_last [$];
  int           n_issue, n_pop, valid_seen, addr_viol, credit_viol, stall_viol;
  logic         prev_stall;
  logic [127:0] prev_data;
  logic         prev_last;

  always @(negedge clk) begin
    if (rstn) begin
      if (bram_en) begin
        if (bram_addr != ADDR_W'(n_issue)) addr_viol++;
        n_issue++;
        if (n_issue - n_pop > int'(DEPTH)) credit_viol++;
      end
      if (stream_if.m_valid) valid_seen++;
      if (prev_stall && (!stream_if.m_valid || stream_if.m_data !== prev_data ||
                         stream_if.m_last !== prev_last)) stall_viol++;
      if (stream_if.m_valid && stream_if.m_ready) begin
        rx_data.push_back(stream_if.m_data);
        rx_last.push_back(stream_if.m_last);
        n_pop++;
      end
      prev_stall = stream_if.m_valid && !stream_if.m_ready;
      prev_data  = stream_if.m_data;
      prev_last  = stream_if.m_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [127:0] row_pat(input int i);
    return {32'h7FFF_FFFF, 32'(2 * i), 32'(-i), 32'(i)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rx_data.delete();
    rx_last.delete();
    n_issue = 0; n_pop = 0; valid_seen = 0;
    addr_viol = 0; credit_viol = 0; stall_viol = 0;
  endtask

  // Start a drain in the current (idle) cycle; returns at the done cycle
  task automatic run_drain(input logic [ADDR_W:0] n, input bit rnd, output int cyc);
    clear_mon();
    start    = 1'b1;
    num_rows = n;
    stream_if.m_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 3000) begin
      if (rnd) stream_if.m_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    stream_if.m_ready = 1'b1;
    check("done_reached", 128'(done), 128'(1));
  endtask

  task automatic check_rows(input string tag, input int n);
    int lasts;
    check({tag, "_count"}, 128'(rx_data.size()), 128'(n));
    lasts = 0;
    for (int k = 0; k < n && k < rx_data.size(); k++) begin
      if (rx_data[k] !== row_pat(k)) check({tag, "_row"}, rx_data[k], row_pat(k));
      if (rx_last[k]) lasts++;
    end
    check({tag, "_last_count"}, 128'(lasts), 128'(1));
    if (rx_last.size() == n) check({tag, "_last_pos"}, 128'(rx_last[n-1]), 128'(1));
  endtask

  int cyc;
  logic [31:0] exp_cs;

  initial begin
    for (int i = 0; i < 1024; i++) bram_mem[i] = row_pat(i);
    rstn = 1'b0; start = 1'b0; num_rows = '0; stream_if.m_ready = 1'b0;
    clear_mon();
    tick(); tick();
    check("rst_bram_en", 128'(bram_en), 128'(0));
    check("rst_m_valid", 128'(stream_if.m_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_checksum", 128'(checksum), 128'(0));
    rstn = 1'b1;
    tick();

    // Full-rate drain of 50 rows with cycle-exact timing checks
    clear_mon();
    start = 1'b1; num_rows = 11'd50; stream_if.m_ready = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy_c1", 128'(busy), 128'(1));
    check("t1_en_c1", 128'(bram_en), 128'(1));
    check("t1_addr_c1", 128'(bram_addr), 128'(0));
    tick(); tick();
    check("t1_valid_c3", 128'(stream_if.m_valid), 128'(0));
    tick();
    check("t1_valid_c4", 128'(stream_if.m_valid), 128'(1));
    check("t1_data_c4", stream_if.m_data, row_pat(0));
    cyc = 4;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    check("t1_done_cycle", 128'(cyc), 128'(54));
    check_rows("t1", 50);
`ifdef DRAIN_CHECKSUM_EN
    exp_cs = 32'd2400;
`else
    exp_cs = 32'd0;
`endif
    check("t1_checksum", 128'(checksum), 128'(exp_cs));
    tick();

    // Pseudo-random backpressure
    run_drain(11'd50, 1'b1, cyc);
    check_rows("t2", 50);
    check("t2_stall_stable", 128'(stall_viol), 128'(0));
    check("t2_credit", 128'(credit_viol), 128'(0));
    check("t2_addr_order", 128'(addr_viol), 128'(0));
    tick();

    // Zero rows
    run_drain(11'd0, 1'b0, cyc);
    check("t3_done_cycle", 128'(cyc), 128'(1));
    check("t3_issues", 128'(n_issue), 128'(0));
    check("t3_valid_seen", 128'(valid_seen), 128'(0));
    tick();

    // Clamp of oversize row count
    run_drain(11'd2047, 1'b0, cyc);
    check("t4_done_cycle", 128'(cyc), 128'(1028));
    check("t4_issues", 128'(n_issue), 128'(1024));
    check("t4_addr_order", 128'(addr_viol), 128'(0));
    check("t4_addr_final", 128'(bram_addr), 128'(1023));
    check_rows("t4", 1024);
    tick();

    // Ignored start during RUN, then reset mid-drain
    clear_mon();
    start = 1'b1; num_rows = 11'd50; stream_if.m_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; num_rows = 11'd3;
    tick();
    start = 1'b0;
    cyc = 0;
    while (rx_data.size() < 7 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("t5_rows_before_rst", 128'(rx_data.size()), 128'(7));
    check("t5_row6", rx_data[6], row_pat(6));
    check("t5_still_busy", 128'(busy), 128'(1));
    rstn = 1'b0;
    tick();
    check("t5_rst_addr", 128'(bram_addr), 128'(0));
    check("t5_rst_en", 128'(bram_en), 128'(0));
    check("t5_rst_valid", 128'(stream_if.m_valid), 128'(0));
    check("t5_rst_data", stream_if.m_data, 128'(0));
    check("t5_rst_last", 128'(stream_if.m_last), 128'(0));
    check("t5_rst_busy", 128'(busy), 128'(0));
    check("t5_rst_done", 128'(done), 128'(0));
    check("t5_rst_checksum", 128'(checksum), 128'(0));
    rstn = 1'b1;
    tick(); tick();
    run_drain(11'd3, 1'b0, cyc);
    check_rows("t5", 3);
    check("t5_issues", 128'(n_issue), 128'(3));
    tick(); tick(); tick();
    check("t5_no_stray_rows", 128'(rx_data.size()), 128'(3));

    // Checksum over constant rows
    for (int i = 0; i < 10; i++) bram_mem[i] = {32'd4, 32'd3, 32'd2, 32'd1};
    run_drain(11'd10, 1'b0, cyc);
`ifdef DRAIN_CHECKSUM_EN
    exp_cs = 32'd100;
`else
    exp_cs = 32'd0;
`endif
    check("t6_checksum_done", 128'(checksum), 128'(exp_cs));
    check("t6_count", 128'(rx_data.size()), 128'(10));
    tick();
    check("t6_checksum_hold", 128'(checksum), 128'(exp_cs));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
